// File: rtl/speed_pi_pwm_if.sv
// Control/status bundle between one motor's speed loop and its supervisor.
// The slave side is the speed stage, and the master side is the controlling logic.
interface speed_pi_pwm_if;
    logic              enable;
    logic [7:0]        setpoint;
    logic [7:0]        speed_in;
    logic              pwm_out;
    logic [7:0]        duty;
    logic signed [8:0] speed_err;
    logic              sat_hi;
    logic              sat_lo;
    logic              upd;

    modport slave (
        input  enable, setpoint, speed_in,
        output pwm_out, duty, speed_err, sat_hi, sat_lo, upd
    );

    modport master (
        output enable, setpoint, speed_in,
        input  pwm_out, duty, speed_err, sat_hi, sat_lo, upd
    );
endinterface

// File: rtl/speed_pi_pwm.sv
// Per-window saturating PI speed loop for one motor, with a double-buffered 8-bit PWM.
// The loop computes one duty value per sample window and applies it at the next PWM period boundary.
module speed_pi_pwm #(
    parameter int SAMPLE_PERIOD = 55610,
    parameter int KP            = 4,
    parameter int KI            = 1,
    parameter int SHIFT         = 2,
    parameter int INT_LIM       = 4095
) (
    input  logic          clk,
    input  logic          reset,
    speed_pi_pwm_if.slave bus
);

    localparam int                WIN_W    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(SAMPLE_PERIOD - 1);
    localparam logic signed [16:0] LIM_P   = 17'(INT_LIM);
    localparam logic signed [16:0] LIM_N   = 17'(-INT_LIM);
    localparam logic signed [23:0] KP_S    = 24'(KP);
    localparam logic signed [23:0] KI_S    = 24'(KI);

    // Each state is named for the work that was registered on entry to it.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_INTEG   = 3'd2,
        S_MULT    = 3'd3,
        S_SUM     = 3'd4
    } state_t;

    state_t             r_state;
    logic [WIN_W-1:0]   r_win_cnt;
    logic [7:0]         r_pwm_cnt;
    logic signed [8:0]  r_err_p0;
    logic signed [15:0] r_integ_p1;
    logic signed [23:0] r_p_p2;
    logic signed [23:0] r_i_p2;
    logic [7:0]         r_duty_pend;
    logic [7:0]         r_duty_act;
    logic signed [8:0]  r_speed_err;
    logic               r_sat_hi;
    logic               r_sat_lo;
    logic               r_upd;

    logic               w_strobe;
    logic               w_pwm_wrap;
    logic               w_hold;
    logic               w_load_new;
    logic signed [16:0] w_integ_sum;
    logic signed [23:0] w_err_ext;
    logic signed [23:0] w_integ_ext;
    logic signed [23:0] w_u;
    logic [7:0]         w_u_sat;
    logic               w_u_hi;
    logic               w_u_lo;

    function automatic logic signed [15:0] clamp_integ(input logic signed [16:0] x);
        logic signed [16:0] c;
        if (x > LIM_P)
            c = LIM_P;
        else if (x < LIM_N)
            c = LIM_N;
        else
            c = x;
        return c[15:0];
    endfunction

    function automatic logic [7:0] sat_u8(input logic signed [23:0] u);
        if (u < 24'sd0)
            return 8'd0;
        else if (u > 24'sd255)
            return 8'hFF;
        else
            return u[7:0];
    endfunction

    assign w_strobe    = (r_win_cnt == WIN_LAST);
    assign w_pwm_wrap  = (r_pwm_cnt == 8'hFF);
    assign w_integ_sum = {r_integ_p1[15], r_integ_p1} + {{8{r_err_p0[8]}}, r_err_p0};
    assign w_err_ext   = {{15{r_err_p0[8]}}, r_err_p0};
    assign w_integ_ext = {{8{r_integ_p1[15]}}, r_integ_p1};
    assign w_u         = (r_p_p2 + r_i_p2) >>> SHIFT;
    assign w_u_sat     = sat_u8(w_u);
    assign w_u_hi      = (w_u > 24'sd255);
    assign w_u_lo      = (w_u < 24'sd0);
    // Anti-windup is based on the saturation flags from the previous window.
    assign w_hold      = (r_sat_hi && (r_err_p0 > 9'sd0)) || (r_sat_lo && (r_err_p0 < 9'sd0));
    // A duty value produced on a period boundary goes straight into the active buffer.
    assign w_load_new  = (r_state == S_MULT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_win_cnt <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_win_cnt <= w_strobe ? '0 : r_win_cnt + WIN_W'(1);
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_err_p0    <= '0;
            r_integ_p1  <= '0;
            r_p_p2      <= '0;
            r_i_p2      <= '0;
            r_duty_pend <= '0;
            r_duty_act  <= '0;
            r_speed_err <= '0;
            r_sat_hi    <= 1'b0;
            r_sat_lo    <= 1'b0;
            r_upd       <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            if (!bus.enable) begin
                r_state     <= S_IDLE;
                r_integ_p1  <= '0;
                r_duty_pend <= '0;
                r_duty_act  <= '0;
                r_sat_hi    <= 1'b0;
                r_sat_lo    <= 1'b0;
            end else begin
                if (w_pwm_wrap)
                    r_duty_act <= w_load_new ? w_u_sat : r_duty_pend;
                case (r_state)
                    // p0: capture the error for this window
                    S_IDLE: begin
                        if (w_strobe) begin
                            r_err_p0 <= $signed({1'b0, bus.setpoint}) - $signed({1'b0, bus.speed_in});
                            r_state  <= S_CAPTURE;
                        end
                    end
                    // p1: update the integrator, clamped
                    S_CAPTURE: begin
                        if (!w_hold)
                            r_integ_p1 <= clamp_integ(w_integ_sum);
                        r_state <= S_INTEG;
                    end
                    // p2: compute the gain products
                    S_INTEG: begin
                        r_p_p2  <= KP_S * w_err_ext;
                        r_i_p2  <= KI_S * w_integ_ext;
                        r_state <= S_MULT;
                    end
                    // output: shift, saturate, and publish the result
                    S_MULT: begin
                        r_duty_pend <= w_u_sat;
                        r_sat_hi    <= w_u_hi;
                        r_sat_lo    <= w_u_lo;
                        r_speed_err <= r_err_p0;
                        r_upd       <= 1'b1;
                        r_state     <= S_SUM;
                    end
                    S_SUM:   r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.pwm_out   = (r_pwm_cnt < r_duty_act);
    assign bus.duty      = r_duty_act;
    assign bus.speed_err = r_speed_err;
    assign bus.sat_hi    = r_sat_hi;
    assign bus.sat_lo    = r_sat_lo;
    assign bus.upd       = r_upd;

endmodule

// File: tb/tb_speed_pi_pwm.sv
// Scoreboard bench for speed_pi_pwm. It uses a short sample window so that every scenario fits in a few thousand cycles.
module tb_speed_pi_pwm;

    localparam int SP      = 600;
    localparam int KP      = 4;
    localparam int KI      = 1;
    localparam int SHIFT   = 2;
    localparam int INT_LIM = 4095;

    typedef struct {
        int duty;
        int err;
        bit hi;
        bit lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned tb_cnt;
    int          checks = 0;
    int          failures = 0;
    int          m_integ = 0;
    bit          m_hi = 1'b0;
    bit          m_lo = 1'b0;
    exp_t        q[$];

    speed_pi_pwm_if bus();

    speed_pi_pwm #(
        .SAMPLE_PERIOD(SP),
        .KP(KP),
        .KI(KI),
        .SHIFT(SHIFT),
        .INT_LIM(INT_LIM)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // tb_cnt tracks the DUT window counter: win_cnt == tb_cnt % SP.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cnt <= 0;
        else        tb_cnt <= tb_cnt + 1;
    end

    task automatic model_clear();
        m_integ = 0;
        m_hi    = 1'b0;
        m_lo    = 1'b0;
    endtask

    task automatic model_push(input int sp, input int spd);
        exp_t e;
        int   err;
        int   s;
        int   u;
        err = sp - spd;
        if (!((m_hi && err > 0) || (m_lo && err < 0))) begin
            s = m_integ + err;
            if (s > INT_LIM)  s = INT_LIM;
            if (s < -INT_LIM) s = -INT_LIM;
            m_integ = s;
        end
        u = (KP * err + KI * m_integ) >>> SHIFT;
        m_hi   = (u > 255);
        m_lo   = (u < 0);
        e.duty = m_hi ? 255 : (m_lo ? 0 : u);
        e.err  = err;
        e.hi   = m_hi;
        e.lo   = m_lo;
        q.push_back(e);
    endtask

    task automatic wait_upd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * SP + 20; i++) begin
            @(negedge clk);
            if (bus.upd === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (bus.duty !== 8'd0) begin failures++; $display("FAIL reset_duty got=%0d exp=0", bus.duty); end
        checks++; if (bus.speed_err !== 9'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", bus.speed_err); end
        checks++; if (bus.sat_hi !== 1'b0 || bus.sat_lo !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", bus.sat_hi, bus.sat_lo); end
        checks++; if (bus.upd !== 1'b0) begin failures++; $display("FAIL reset_upd got=%b exp=0", bus.upd); end
        checks++; if (bus.pwm_out !== 1'b0) begin failures++; $display("FAIL reset_pwm got=%b exp=0", bus.pwm_out); end
        bus.enable   = 1'b1;
        bus.setpoint = 8'd100;
        bus.speed_in = 8'd100;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_steady();
        bit   ok;
        exp_t e;
        int   high;
        for (int w = 0; w < 2; w++) begin
            model_push(100, 100);
            wait_upd(ok);
            checks++;
            if (!ok) begin
                failures++; q.delete();
                $display("FAIL steady_upd w=%0d got=none exp=upd", w);
            end else begin
                e = q.pop_front();
                checks++; if (bus.speed_err !== 9'(e.err)) begin failures++; $display("FAIL steady_err got=%0d exp=%0d", bus.speed_err, e.err); end
                checks++; if (bus.sat_hi !== 1'b0 || bus.sat_lo !== 1'b0) begin failures++; $display("FAIL steady_flags got=%b%b exp=00", bus.sat_hi, bus.sat_lo); end
                checks++; if ((tb_cnt % SP) != 3) begin failures++; $display("FAIL steady_latency got=%0d exp=3", tb_cnt % SP); end
                @(negedge clk);
                checks++; if (bus.upd !== 1'b0) begin failures++; $display("FAIL steady_upd_pulse got=%b exp=0", bus.upd); end
                high = 0;
                repeat (256) begin @(negedge clk); high += int'(bus.pwm_out); end
                checks++; if (bus.duty !== 8'(e.duty) || high != 0) begin failures++; $display("FAIL steady_duty got=%0d/%0d exp=0/0", bus.duty, high); end
            end
        end
    endtask

    task automatic test_track();
        int   exp_duty[2] = '{50, 60};
        bit   ok;
        exp_t e;
        int   high;
        for (int w = 0; w < 2; w++) begin
            bus.setpoint = 8'd100;
            bus.speed_in = 8'd60;
            model_push(100, 60);
            wait_upd(ok);
            checks++;
            if (!ok) begin
                failures++; q.delete();
                $display("FAIL track_upd w=%0d got=none exp=upd", w);
            end else begin
                e = q.pop_front();
                checks++; if (bus.speed_err !== 9'sd40) begin failures++; $display("FAIL track_err got=%0d exp=40", bus.speed_err); end
                checks++; if ({bus.sat_hi, bus.sat_lo} !== {e.hi, e.lo}) begin failures++; $display("FAIL track_flags got=%b%b exp=%b%b", bus.sat_hi, bus.sat_lo, e.hi, e.lo); end
                checks++; if ((tb_cnt % SP) != 3) begin failures++; $display("FAIL track_latency got=%0d exp=3", tb_cnt % SP); end
                repeat (257) @(negedge clk);
                checks++; if (bus.duty !== 8'(exp_duty[w])) begin failures++; $display("FAIL track_duty w=%0d got=%0d exp=%0d", w, bus.duty, exp_duty[w]); end
                if (w == 0) begin
                    high = 0;
                    repeat (256) begin @(negedge clk); high += int'(bus.pwm_out); end
                    checks++; if (high != 50) begin failures++; $display("FAIL track_pwm_high got=%0d exp=50", high); end
                end
            end
        end
    endtask

    task automatic test_saturation();
        int   sp_t[6]   = '{255, 255, 128, 0,   0,   200};
        int   spd_t[6]  = '{0,   0,   128, 200, 200, 0};
        int   duty_t[6] = '{255, 255, 63,  0,   0,   200};
        bit   hi_t[6]   = '{1, 1, 0, 0, 0, 0};
        bit   lo_t[6]   = '{0, 0, 0, 1, 1, 0};
        bit   clr_t[6]  = '{1, 0, 0, 1, 0, 0};
        bit   ok;
        exp_t e;
        int   high;
        for (int r = 0; r < 6; r++) begin
            if (clr_t[r]) begin
                bus.enable = 1'b0;
                @(negedge clk);
                checks++; if (bus.duty !== 8'd0 || bus.sat_hi !== 1'b0 || bus.sat_lo !== 1'b0) begin failures++; $display("FAIL sat_disable got=%0d/%b%b exp=0/00", bus.duty, bus.sat_hi, bus.sat_lo); end
                bus.enable = 1'b1;
                model_clear();
            end
            bus.setpoint = 8'(sp_t[r]);
            bus.speed_in = 8'(spd_t[r]);
            model_push(sp_t[r], spd_t[r]);
            wait_upd(ok);
            checks++;
            if (!ok) begin
                failures++; q.delete();
                $display("FAIL sat_upd r=%0d got=none exp=upd", r);
            end else begin
                e = q.pop_front();
                checks++; if (bus.speed_err !== 9'(e.err)) begin failures++; $display("FAIL sat_err r=%0d got=%0d exp=%0d", r, bus.speed_err, e.err); end
                checks++; if (bus.sat_hi !== hi_t[r] || bus.sat_lo !== lo_t[r]) begin failures++; $display("FAIL sat_flags r=%0d got=%b%b exp=%b%b", r, bus.sat_hi, bus.sat_lo, hi_t[r], lo_t[r]); end
                repeat (257) @(negedge clk);
                checks++; if (bus.duty !== 8'(duty_t[r]) || e.duty != duty_t[r]) begin failures++; $display("FAIL sat_duty r=%0d got=%0d model=%0d exp=%0d", r, bus.duty, e.duty, duty_t[r]); end
                if (r == 0) begin
                    high = 0;
                    repeat (256) begin @(negedge clk); high += int'(bus.pwm_out); end
                    checks++; if (high != 255) begin failures++; $display("FAIL sat_pwm_high got=%0d exp=255", high); end
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        bit   ok;
        bit   seen;
        exp_t e;
        bus.enable = 1'b0;
        @(negedge clk);
        bus.enable   = 1'b1;
        bus.setpoint = 8'd100;
        bus.speed_in = 8'd60;
        model_clear();
        model_push(100, 60);
        wait_upd(ok);
        checks++; if (!ok) begin failures++; q.delete(); $display("FAIL drop_first_upd got=none exp=upd"); end
        else void'(q.pop_front());
        repeat (257) @(negedge clk);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.pwm_out === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen || bus.duty !== 8'd50) begin failures++; $display("FAIL drop_high_phase got=%b/%0d exp=1/50", seen, bus.duty); end
        bus.enable = 1'b0;
        @(negedge clk);
        checks++; if (bus.pwm_out !== 1'b0) begin failures++; $display("FAIL drop_pwm got=%b exp=0", bus.pwm_out); end
        checks++; if (bus.duty !== 8'd0) begin failures++; $display("FAIL drop_duty got=%0d exp=0", bus.duty); end
        checks++; if (bus.speed_err !== 9'sd40) begin failures++; $display("FAIL drop_err_hold got=%0d exp=40", bus.speed_err); end
        repeat ($urandom_range(5, 200)) @(negedge clk);
        bus.enable = 1'b1;
        model_clear();
        model_push(100, 60);
        wait_upd(ok);
        checks++;
        if (!ok) begin
            failures++; q.delete();
            $display("FAIL drop_reenable_upd got=none exp=upd");
        end else begin
            e = q.pop_front();
            checks++; if ((tb_cnt % SP) != 3) begin failures++; $display("FAIL drop_reenable_latency got=%0d exp=3", tb_cnt % SP); end
            repeat (257) @(negedge clk);
            checks++; if (bus.duty !== 8'(e.duty) || e.duty != 50) begin failures++; $display("FAIL drop_reenable_duty got=%0d exp=50", bus.duty); end
        end
    endtask

    task automatic test_reset_mid_mult();
        bit   hit;
        int   n;
        exp_t e;
        hit = 1'b0;
        for (int i = 0; i < SP + 10; i++) begin
            @(negedge clk);
            if ((tb_cnt % SP) == 2) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) begin failures++; $display("FAIL rst_mult_reach got=miss exp=win2"); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.duty !== 8'd0 || bus.pwm_out !== 1'b0) begin failures++; $display("FAIL rst_mult_pwm got=%0d/%b exp=0/0", bus.duty, bus.pwm_out); end
        checks++; if (bus.speed_err !== 9'd0 || bus.upd !== 1'b0) begin failures++; $display("FAIL rst_mult_err got=%0d/%b exp=0/0", bus.speed_err, bus.upd); end
        checks++; if (bus.sat_hi !== 1'b0 || bus.sat_lo !== 1'b0) begin failures++; $display("FAIL rst_mult_flags got=%b%b exp=00", bus.sat_hi, bus.sat_lo); end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        model_push(100, 60);
        n = 0;
        for (int i = 0; i < 2 * SP + 20; i++) begin
            @(negedge clk);
            n++;
            if (bus.upd === 1'b1) break;
        end
        checks++;
        if (bus.upd !== 1'b1) begin
            failures++; q.delete();
            $display("FAIL rst_mult_first_upd got=none exp=upd");
        end else begin
            e = q.pop_front();
            checks++; if (n < SP || (tb_cnt % SP) != 3) begin failures++; $display("FAIL rst_mult_latency got=%0d exp>=%0d", n, SP); end
            checks++; if (bus.speed_err !== 9'(e.err)) begin failures++; $display("FAIL rst_mult_err_after got=%0d exp=%0d", bus.speed_err, e.err); end
            repeat (257) @(negedge clk);
            checks++; if (bus.duty !== 8'(e.duty)) begin failures++; $display("FAIL rst_mult_duty got=%0d exp=%0d", bus.duty, e.duty); end
        end
    endtask

    initial begin
        bus.enable   = 1'b0;
        bus.setpoint = 8'd0;
        bus.speed_in = 8'd0;
        rst_n        = 1'b0;
        test_reset();
        test_steady();
        test_track();
        test_saturation();
        test_enable_drop();
        test_reset_mid_mult();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
